// File: rtl/crinject_stage.sv
// crinject_stage
// Registered local-flit injection stage for the bufferless deflection router.
// Every channel flit passes through one pipeline register. Flits from the
// local core wait in a small FIFO. At most one of them per cycle is placed
// into the lowest-index channel that carries no flit. As it is injected, its
// direction field is rebuilt from its destination and this router's
// coordinates.
//
// Flit layout (FW = MW+3+YW+XW bits): {meta[MW], dir[3], row[YW], col[XW]}
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-high reset
//   in_flit     NCH channel flits, channel i at [i*FW +: FW]
//   in_valid    per-channel valid
//   inj_flit    local flit to buffer (its dir field is ignored)
//   inj_valid   local flit offered
//   inj_ready   FIFO can accept a flit this cycle (low while rst is high)
//   out_flit    registered channel flits
//   out_valid   registered channel valids
//   fifo_count  injection FIFO occupancy
//
// Optional feature, enabled by defining CRINJ_STATS_EN:
//   inj_total   saturating 16-bit count of injections
//   inj_blocked saturating 16-bit count of cycles in which the FIFO holds a
//               flit but every channel is busy
module crinject_stage #(
  parameter int NCH      = 4,
  parameter int XW       = 3,
  parameter int YW       = 3,
  parameter int MW       = 2,
  parameter int ROUTER_X = 4,
  parameter int ROUTER_Y = 4,
  parameter int DEPTH    = 4,
  localparam int FW      = MW + 3 + YW + XW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH*FW-1:0]          in_flit,
  input  logic [NCH-1:0]             in_valid,
  input  logic [FW-1:0]              inj_flit,
  input  logic                       inj_valid,
  output logic                       inj_ready,
  output logic [NCH*FW-1:0]          out_flit,
  output logic [NCH-1:0]             out_valid,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
`ifdef CRINJ_STATS_EN
  ,
  output logic [15:0]                inj_total,
  output logic [15:0]                inj_blocked
`endif
);

  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int DIR_LSB = XW + YW;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [XW-1:0] RX       = XW'(ROUTER_X);
  localparam logic [YW-1:0] RY       = YW'(ROUTER_Y);
  localparam logic [FW-1:0] DIR_MASK = {{MW{1'b0}}, 3'b111, {(YW + XW){1'b0}}};

  localparam logic [2:0] DIR_EAST  = 3'd0;
  localparam logic [2:0] DIR_WEST  = 3'd1;
  localparam logic [2:0] DIR_NORTH = 3'd2;
  localparam logic [2:0] DIR_SOUTH = 3'd3;
  localparam logic [2:0] DIR_LOCAL = 3'd4;

  logic [FW-1:0]  mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;

  logic           push;
  logic           pop;
  logic           taken;
  logic [NCH-1:0] inj_sel;

  logic [FW-1:0]  head;
  logic [FW-1:0]  head_fixed;
  logic [XW-1:0]  head_col;
  logic [YW-1:0]  head_row;
  logic [2:0]     head_dir;

  // inj_ready looks only at the current occupancy. A pop in the same cycle
  // does not make room early, which keeps the ready path short.
  assign fifo_count = count;
  assign inj_ready  = !rst && (count < DEPTH_C);
  assign push       = inj_valid && inj_ready;

  // A pop needs a buffered flit and at least one idle channel. count is the
  // value before this edge's push, so a flit cannot be pushed and injected
  // in the same cycle.
  assign pop        = (count != '0) && !(&in_valid);

  assign head       = mem[rd_ptr];
  assign head_col   = head[XW-1:0];
  assign head_row   = head[XW +: YW];

  // Choose the lowest-index idle channel as a one-hot vector. It stays all
  // zero when there is nothing to inject.
  always_comb begin
    inj_sel = '0;
    taken   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!in_valid[i] && !taken) begin
        inj_sel[i] = pop;
        taken      = 1'b1;
      end
    end
  end

  // Route the head flit with X first, then Y. Only the dir field is
  // replaced; meta, row and col are copied unchanged.
  always_comb begin
    head_dir = DIR_LOCAL;
    if (head_col > RX) begin
      head_dir = DIR_EAST;
    end else if (head_col < RX) begin
      head_dir = DIR_WEST;
    end else if (head_row > RY) begin
      head_dir = DIR_NORTH;
    end else if (head_row < RY) begin
      head_dir = DIR_SOUTH;
    end
    head_fixed = (head & ~DIR_MASK) | (FW'(head_dir) << DIR_LSB);
  end

  // Output pipeline register. A valid channel flit always wins. The one
  // selected idle channel takes the injected flit. Every other idle channel
  // is cleared to zero so that no stale data leaves the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_flit  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (in_valid[i]) begin
          out_valid[i]          <= 1'b1;
          out_flit[i*FW +: FW]  <= in_flit[i*FW +: FW];
        end else if (inj_sel[i]) begin
          out_valid[i]          <= 1'b1;
          out_flit[i*FW +: FW]  <= head_fixed;
        end else begin
          out_valid[i]          <= 1'b0;
          out_flit[i*FW +: FW]  <= '0;
        end
      end
    end
  end

  // FIFO storage has no reset. An empty FIFO is never read, so the contents
  // left behind by a reset do not matter.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= inj_flit;
    end
  end

  // The pointers wrap naturally because DEPTH is a power of two. The count
  // cannot exceed DEPTH because push is gated by inj_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef CRINJ_STATS_EN
  // Both statistics counters stop at all-ones instead of wrapping, so a
  // long run never reports a misleading small value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_total   <= '0;
      inj_blocked <= '0;
    end else begin
      if (pop && (inj_total != 16'hFFFF)) begin
        inj_total <= inj_total + 16'd1;
      end
      if ((count != '0) && (&in_valid) && (inj_blocked != 16'hFFFF)) begin
        inj_blocked <= inj_blocked + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_crinject_stage.sv
// Testbench for crinject_stage with the default parameters
// (NCH=4, 3-bit coordinates, 2-bit meta, router at (4,4), DEPTH=4).
// A table of single-cycle vectors covers pass-through, injection and the
// dir encoding. Hand-written sequences cover the full-FIFO, reset and
// optional statistics cases.
module tb_crinject_stage;

  localparam int NCH   = 4;
  localparam int XW    = 3;
  localparam int YW    = 3;
  localparam int MW    = 2;
  localparam int DEPTH = 4;
  localparam int FW    = MW + 3 + YW + XW;
  localparam int CW    = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic [NCH*FW-1:0] in_flit;
  logic [NCH-1:0]    in_valid;
  logic [FW-1:0]     inj_flit;
  logic              inj_valid;
  logic              inj_ready;
  logic [NCH*FW-1:0] out_flit;
  logic [NCH-1:0]    out_valid;
  logic [CW-1:0]     fifo_count;
`ifdef CRINJ_STATS_EN
  logic [15:0]       inj_total;
  logic [15:0]       inj_blocked;
`endif

  int checks   = 0;
  int failures = 0;

  crinject_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_flit    (in_flit),
    .in_valid   (in_valid),
    .inj_flit   (inj_flit),
    .inj_valid  (inj_valid),
    .inj_ready  (inj_ready),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .fifo_count (fifo_count)
`ifdef CRINJ_STATS_EN
    ,
    .inj_total  (inj_total),
    .inj_blocked(inj_blocked)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0]    in_valid;
    logic [NCH*FW-1:0] in_flit;
    logic              inj_valid;
    logic [FW-1:0]     inj_flit;
    logic [NCH-1:0]    exp_valid;
    logic [NCH*FW-1:0] exp_flit;
    logic [CW-1:0]     exp_count;
    logic              exp_ready;
  } vec_t;

  // Builds a flit from its fields: {meta, dir, row, col}.
  function automatic logic [FW-1:0] mk(input int meta, input int dir,
                                       input int row, input int col);
    return {MW'(meta), 3'(dir), YW'(row), XW'(col)};
  endfunction

  // One comparison: a mismatch prints a FAIL line and the run continues.
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives the inputs away from the edge, lets one rising edge pass, and
  // returns on the following falling edge, where the outputs are sampled.
  task automatic applyStimulus(input logic [NCH-1:0] v,
                               input logic [NCH*FW-1:0] f,
                               input logic iv, input logic [FW-1:0] inf);
    in_valid  = v;
    in_flit   = f;
    inj_valid = iv;
    inj_flit  = inf;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [NCH-1:0] ev,
                             input logic [NCH*FW-1:0] ef,
                             input logic [CW-1:0] ec, input logic er);
    check({name, "/out_valid"}, 64'(out_valid), 64'(ev));
    check({name, "/out_flit"}, 64'(out_flit), 64'(ef));
    check({name, "/fifo_count"}, 64'(fifo_count), 64'(ec));
    check({name, "/inj_ready"}, 64'(inj_ready), 64'(er));
  endtask

  vec_t vecs[10];
  logic [FW-1:0] fa, fb, fg, fc, z;

  initial begin
    fa = mk(1, 5, 3, 2);
    fb = mk(2, 6, 1, 7);
    fg = mk(3, 7, 7, 7);
    fc = mk(2, 2, 2, 2);
    z  = '0;

    // Each vector starts from the state left by the previous one.
    // Dir rule against router (4,4): col>4 east(0), col<4 west(1),
    // col==4 with row>4 north(2), row<4 south(3), both equal local(4).
    vecs[0] = '{4'b0101, {fg, fb, fg, fa}, 1'b1, mk(1, 7, 2, 4),
                4'b0101, {z, fb, z, fa}, 3'd1, 1'b1};
    vecs[1] = '{4'b0101, {fg, fb, fg, fa}, 1'b0, z,
                4'b0111, {z, fb, mk(1, 3, 2, 4), fa}, 3'd0, 1'b1};
    vecs[2] = '{4'b0000, {fg, fg, fg, fg}, 1'b1, mk(2, 0, 4, 4),
                4'b0000, {z, z, z, z}, 3'd1, 1'b1};
    vecs[3] = '{4'b0000, {fg, fg, fg, fg}, 1'b1, mk(3, 0, 6, 1),
                4'b0001, {z, z, z, mk(2, 4, 4, 4)}, 3'd1, 1'b1};
    vecs[4] = '{4'b0000, {fg, fg, fg, fg}, 1'b1, mk(0, 5, 7, 4),
                4'b0001, {z, z, z, mk(3, 1, 6, 1)}, 3'd1, 1'b1};
    vecs[5] = '{4'b0000, {fg, fg, fg, fg}, 1'b0, z,
                4'b0001, {z, z, z, mk(0, 2, 7, 4)}, 3'd0, 1'b1};
    vecs[6] = '{4'b1011, {fc, fg, fb, fa}, 1'b1, mk(1, 0, 5, 5),
                4'b1011, {fc, z, fb, fa}, 3'd1, 1'b1};
    vecs[7] = '{4'b1011, {fc, fg, fb, fa}, 1'b0, z,
                4'b1111, {fc, mk(1, 0, 5, 5), fb, fa}, 3'd0, 1'b1};
    vecs[8] = '{4'b0000, {fg, fg, fg, fg}, 1'b1, mk(0, 6, 0, 0),
                4'b0000, {z, z, z, z}, 3'd1, 1'b1};
    vecs[9] = '{4'b1110, {fc, fc, fc, fg}, 1'b0, z,
                4'b1111, {fc, fc, fc, mk(0, 1, 0, 0)}, 3'd0, 1'b1};

    rst       = 1'b1;
    in_valid  = '0;
    in_flit   = '0;
    inj_valid = 1'b0;
    inj_flit  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset", 4'b0000, '0, 3'd0, 1'b0);
    rst = 1'b0;
    #1;
    check("reset_release/inj_ready", 64'(inj_ready), 64'd1);

    // Table-driven vectors
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].in_valid, vecs[v].in_flit,
                    vecs[v].inj_valid, vecs[v].inj_flit);
      checkOutput($sformatf("vec%0d", v), vecs[v].exp_valid,
                  vecs[v].exp_flit, vecs[v].exp_count, vecs[v].exp_ready);
    end

    // All channels busy: the FIFO fills to DEPTH and the fifth flit is refused
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111, {fc, fc, fc, fc}, 1'b1, mk(k, 5, 1, k));
      checkOutput($sformatf("fill%0d", k), 4'b1111, {fc, fc, fc, fc},
                  (k < 3) ? CW'(k + 1) : CW'(4), (k < 3) ? 1'b1 : 1'b0);
    end
    // Drain on channel 0 in acceptance order; every flit goes west (col<4)
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b1110, {fc, fc, fc, fg}, 1'b0, z);
      checkOutput($sformatf("drain%0d", k), 4'b1111,
                  {fc, fc, fc, mk(k, 1, 1, k)}, CW'(3 - k), 1'b1);
    end
    applyStimulus(4'b1110, {fc, fc, fc, fg}, 1'b0, z);
    checkOutput("drain_empty", 4'b1110, {fc, fc, fc, z}, 3'd0, 1'b1);

    // Reset while three flits are buffered: they are lost
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b1111, {fa, fa, fa, fa}, 1'b1, mk(1, 0, 3, 3));
    end
    check("pre_reset/fifo_count", 64'(fifo_count), 64'd3);
    rst = 1'b1;
    #1;
    checkOutput("mid_reset", 4'b0000, '0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset/inj_ready", 64'(inj_ready), 64'd1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(4'b0000, {fg, fg, fg, fg}, 1'b0, z);
      checkOutput($sformatf("post_reset%0d", k), 4'b0000, '0, 3'd0, 1'b1);
    end

`ifdef CRINJ_STATS_EN
    // Statistics: 10 blocked cycles followed by 3 injections
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("stats_reset/inj_total", 64'(inj_total), 64'd0);
    check("stats_reset/inj_blocked", 64'(inj_blocked), 64'd0);
    // The first push sees an empty FIFO, so it is not a blocked cycle.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b1111, {fa, fa, fa, fa}, 1'b1, mk(0, 0, 4, 4));
    end
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b1111, {fa, fa, fa, fa}, 1'b0, z);
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b0000, {fg, fg, fg, fg}, 1'b0, z);
    end
    check("stats/inj_blocked", 64'(inj_blocked), 64'd10);
    check("stats/inj_total", 64'(inj_total), 64'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
